// File: rtl/nibble_serial_adder_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_pkg
// Shared definitions for the nibble-serial adder controller.
//   state_t : controller state encoding (IDLE / RUN / DONE, 2'd3 unused)
//   SLICE_W : width of one adder pass (one nibble)
// -----------------------------------------------------------------------------
package nibble_serial_adder_ctrl_pkg;

  localparam int SLICE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nibble_serial_adder_ctrl_if.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl_if
// Operand/result handshake bundle for the nibble-serial adder.
//   in_valid/in_ready   : operand handshake (a, b, c_in travel with it)
//   out_valid/out_ready : result handshake (sum, c_out, ovf travel with it)
//   busy                : controller is working on or holding a result
// Modports:
//   master : operand source / result consumer side
//   slave  : adder controller side
// -----------------------------------------------------------------------------
interface nibble_serial_adder_ctrl_if #(
  parameter int WORD_W = 16
);

  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] a;
  logic [WORD_W-1:0] b;
  logic              c_in;
  logic              out_valid;
  logic              out_ready;
  logic [WORD_W-1:0] sum;
  logic              c_out;
  logic              ovf;
  logic              busy;

  modport master (
    output in_valid, a, b, c_in, out_ready,
    input  in_ready, out_valid, sum, c_out, ovf, busy
  );

  modport slave (
    input  in_valid, a, b, c_in, out_ready,
    output in_ready, out_valid, sum, c_out, ovf, busy
  );

endinterface

// File: rtl/full_adder_4_bit.sv
// -----------------------------------------------------------------------------
// full_adder_4_bit
// Plain 4-bit ripple-carry adder built from single-bit full adders.
//   c_out : carry out of bit 3
//   sum   : 4-bit sum
//   a, b  : 4-bit addends
//   c_in  : carry into bit 0
// -----------------------------------------------------------------------------
module full_adder_4_bit (
  output logic       c_out,
  output logic [3:0] sum,
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in
);

  logic [4:0] carry;

  assign carry[0] = c_in;

  // One full-adder cell per bit, carry rippling upward.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    assign sum[i]     = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  assign c_out = carry[4];

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder_ctrl
// Adds two WORD_W-bit operands using a single shared 4-bit adder, one nibble
// per clock, with a registered carry linking consecutive nibbles.
//   clk   : rising-edge clock
//   rst_n : synchronous active-low reset
//   bus   : slave side of the operand/result handshake bundle
//           (in_valid/in_ready/a/b/c_in in, out_valid/out_ready/sum/c_out/ovf
//           out, plus busy)
// -----------------------------------------------------------------------------
module nibble_serial_adder_ctrl
  import nibble_serial_adder_ctrl_pkg::*;
#(
  parameter int WORD_W = 16
) (
  input logic                       clk,
  input logic                       rst_n,
  nibble_serial_adder_ctrl_if.slave bus
);

  localparam int NUM_SLICES = WORD_W / SLICE_W;
  localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

  state_t                               state;
  logic [IDX_W-1:0]                     idx;
  logic                                 carry;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   a_reg;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   b_reg;
  logic [NUM_SLICES-1:0][SLICE_W-1:0]   sum_reg;
  logic                                 c_out_reg;
  logic                                 ovf_reg;

  logic [SLICE_W-1:0] fa_sum;
  logic               fa_c_out;
  logic               accept;

  // The shared adder always works on the nibble selected by idx; its result
  // is only committed while in RUN.
  full_adder_4_bit u_adder (
    .c_out (fa_c_out),
    .sum   (fa_sum),
    .a     (a_reg[idx]),
    .b     (b_reg[idx]),
    .c_in  (carry)
  );

  // In DONE the input side follows out_ready so that a retiring result and a
  // new request can share the same edge.
  assign bus.in_ready  = (state == IDLE) || ((state == DONE) && bus.out_ready);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.sum       = sum_reg;
  assign bus.c_out     = c_out_reg;
  assign bus.ovf       = ovf_reg;

  assign accept = bus.in_valid && bus.in_ready;

  // Controller FSM: latch operands on accept, walk the nibbles LSB first,
  // then hold the result until the consumer takes it. Reset wins over
  // everything and throws away any partial result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      idx       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      c_out_reg <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            a_reg   <= bus.a;
            b_reg   <= bus.b;
            carry   <= bus.c_in;
            idx     <= '0;
            sum_reg <= '0;
            state   <= RUN;
          end
        end

        RUN: begin
          sum_reg[idx] <= fa_sum;
          carry        <= fa_c_out;
          idx          <= idx + IDX_W'(1);
          if (idx == LAST_IDX) begin
            c_out_reg <= fa_c_out;
            // Signed overflow: like-signed operands producing an opposite sign.
            ovf_reg   <= (a_reg[NUM_SLICES-1][SLICE_W-1] == b_reg[NUM_SLICES-1][SLICE_W-1]) &&
                         (fa_sum[SLICE_W-1] != a_reg[NUM_SLICES-1][SLICE_W-1]);
            state     <= DONE;
          end
        end

        DONE: begin
          if (bus.out_ready) begin
            if (bus.in_valid) begin
              a_reg   <= bus.a;
              b_reg   <= bus.b;
              carry   <= bus.c_in;
              idx     <= '0;
              sum_reg <= '0;
              state   <= RUN;
            end else begin
              state <= IDLE;
            end
          end
        end

        // The unused encoding falls back to IDLE.
        default: begin
          state <= IDLE;
          idx   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// -----------------------------------------------------------------------------
// tb_nibble_serial_adder_ctrl
// Directed test of nibble_serial_adder_ctrl with WORD_W=16: basic adds, carry
// ripple, carry-in, overflow, backpressure, back-to-back issue and a reset
// landing in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_nibble_serial_adder_ctrl;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  nibble_serial_adder_ctrl_if #(.WORD_W(16)) bus ();

  nibble_serial_adder_ctrl #(.WORD_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges despite the bounded waits.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, required finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", tag, got, exp);
    end
  endtask

  // Move to 1 ns after the next rising edge, where inputs are driven and
  // outputs sampled.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands and hold them until the controller takes them. Returns
  // just after the accepting edge with in_valid dropped.
  task automatic applyStimulus(input logic [15:0] av, input logic [15:0] bv, input logic cin);
    int n;
    bus.a        = av;
    bus.b        = bv;
    bus.c_in     = cin;
    bus.in_valid = 1'b1;
    n = 0;
    while (!bus.in_ready && n < 20) begin
      tick();
      n++;
    end
    if (n == 20) checkOutput("accept_timeout", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  // Count edges after the accepting edge until out_valid is seen.
  task automatic waitResult(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Full operation with out_ready held high; checks latency and result.
  task automatic runOp(input string tag, input logic [15:0] av, input logic [15:0] bv,
                       input logic cin, input logic [15:0] exp_sum,
                       input logic exp_c, input logic exp_ovf);
    int lat;
    applyStimulus(av, bv, cin);
    waitResult(lat);
    checkOutput({tag, "_latency"}, 32'(lat), 32'd4);
    checkOutput({tag, "_sum"}, 32'(bus.sum), 32'(exp_sum));
    checkOutput({tag, "_c_out"}, 32'(bus.c_out), 32'(exp_c));
    checkOutput({tag, "_ovf"}, 32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    int lat;
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.c_in      = 1'b0;
    bus.out_ready = 1'b1;

    tick();
    tick();
    rst_n = 1'b1;

    $display("[TB] reset state");
    checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_busy", 32'(bus.busy), 32'd0);
    checkOutput("rst_sum", 32'(bus.sum), 32'd0);
    checkOutput("rst_c_out", 32'(bus.c_out), 32'd0);
    checkOutput("rst_ovf", 32'(bus.ovf), 32'd0);

    $display("[TB] basic add");
    runOp("basic", 16'h1234, 16'h0FED, 1'b0, 16'h2221, 1'b0, 1'b0);
    checkOutput("basic_in_ready_done", 32'(bus.in_ready), 32'd1);
    tick();
    checkOutput("basic_idle_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("basic_idle_busy", 32'(bus.busy), 32'd0);
    checkOutput("basic_idle_sum_kept", 32'(bus.sum), 32'h2221);

    $display("[TB] carry ripple and overflow");
    runOp("ripple", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    tick();
    runOp("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    tick();
    runOp("ovf_neg", 16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);
    tick();

    $display("[TB] carry in");
    runOp("cin_nib", 16'h0009, 16'h0006, 1'b1, 16'h0010, 1'b0, 1'b0);
    tick();
    runOp("cin_full", 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0);
    tick();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    runOp("bp", 16'hABCD, 16'h1111, 1'b0, 16'hBCDE, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      // Operand changes while holding must not leak into the result.
      bus.a = 16'h5555 + 16'(i);
      tick();
      checkOutput($sformatf("bp_hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
      checkOutput($sformatf("bp_hold_sum_%0d", i), 32'(bus.sum), 32'hBCDE);
      checkOutput($sformatf("bp_hold_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
    end
    checkOutput("bp_hold_c_out", 32'(bus.c_out), 32'd0);
    checkOutput("bp_hold_ovf", 32'(bus.ovf), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    checkOutput("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("bp_release_busy", 32'(bus.busy), 32'd0);

    $display("[TB] back-to-back");
    bus.out_ready = 1'b0;
    runOp("b2b_first", 16'h0005, 16'h0007, 1'b0, 16'h000C, 1'b0, 1'b0);
    bus.a         = 16'h0001;
    bus.b         = 16'h0002;
    bus.c_in      = 1'b0;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    checkOutput("b2b_in_ready_pass", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    checkOutput("b2b_no_idle_busy", 32'(bus.busy), 32'd1);
    checkOutput("b2b_retired_valid", 32'(bus.out_valid), 32'd0);
    waitResult(lat);
    checkOutput("b2b_second_latency", 32'(lat), 32'd4);
    checkOutput("b2b_second_sum", 32'(bus.sum), 32'h0003);
    tick();

    $display("[TB] reset mid-operation");
    applyStimulus(16'h1111, 16'h2222, 1'b0);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("midrst_sum", 32'(bus.sum), 32'd0);
    checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_c_out", 32'(bus.c_out), 32'd0);
    // Nothing should surface from the aborted operation.
    tick();
    tick();
    tick();
    checkOutput("midrst_no_stale_valid", 32'(bus.out_valid), 32'd0);
    runOp("after_rst", 16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_serial_adder_ctrl.md
Name: nibble_serial_adder_ctrl

Overview:
- Sequencer that adds two WORD_W-bit operands with one shared 4-bit ripple adder, `full_adder_4_bit`, taking one nibble slice per clock.
- A registered carry links each slice to the next.
- Operands enter and results leave on valid/ready handshakes.
- Sits between the operand source (register file / test stimulus) and any result consumer; trades latency for a single adder instance.

Parameters:
- WORD_W, 16, operand/result width; must be a multiple of 4, legal range 4..64.
- NUM_SLICES, WORD_W/4, derived (localparam), number of adder passes per operation.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operand request
- in_ready  output  1  controller can accept operands
- a  input  WORD_W  operand A
- b  input  WORD_W  operand B
- c_in  input  1  carry into LSB slice
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WORD_W  registered sum
- c_out  output  1  carry out of MSB slice
- ovf  output  1  two's-complement overflow
- busy  output  1  high in RUN or DONE

Behaviour:
- Reset (rst_n low at a clk edge):
  - state=IDLE, slice index=0, carry reg=0.
  - sum=0, c_out=0, ovf=0, out_valid=0.
  - Operand regs cleared.
- Reset overrides everything, including mid-RUN or in DONE. A partial result is discarded and never presented.
- States:
  - IDLE: in_ready=1, out_valid=0, busy=0.
    - On in_valid&&in_ready: latch a, b; carry reg<=c_in; idx<=0; sum<=0; go RUN.
  - RUN: in_ready=0, out_valid=0, busy=1.
    - Each cycle the adder sees a[4*idx+:4], b[4*idx+:4] and the carry reg.
    - sum[4*idx+:4]<=adder sum; carry reg<=adder c_out; idx<=idx+1.
    - When idx==NUM_SLICES-1: c_out<=adder c_out; ovf<=(a[MSB]==b[MSB])&&(final sum[MSB]!=a[MSB]); go DONE.
  - DONE: out_valid=1, busy=1.
    - sum/c_out/ovf held stable until handshake.
    - in_ready=out_ready (pass-through). This allows back-to-back operation.
    - out_ready=0: stay DONE, all outputs unchanged.
    - out_ready=1, in_valid=0: go IDLE. sum/c_out/ovf keep their last values; out_valid drops.
    - out_ready=1, in_valid=1: result retires and new operands are latched in the same edge; go RUN (idx=0).
- Latency: out_valid rises exactly NUM_SLICES cycles after the accepting edge (4 for WORD_W=16).
- Throughput:
  - Back-to-back: one result per NUM_SLICES+1 cycles.
  - Via IDLE: NUM_SLICES+2 cycles.
- Operand inputs are sampled only at the accepting edge. Changes during RUN/DONE are ignored.
- in_valid during RUN is ignored; the requester must hold it until in_ready.
- Arithmetic:
  - Unsigned modulo 2^WORD_W with carry out.
  - ovf computed from latched operand sign bits per the RUN formula above.
- idx width: clog2(NUM_SLICES), minimum 1 bit. For NUM_SLICES=1, RUN lasts one cycle.

Decomposition:
- Shared package holds:
  - state encoding constants: IDLE=2'd0, RUN=2'd1, DONE=2'd2; 2'd3 is illegal and recovers to IDLE.
  - SLICE_W=4 constant.
- Sub-module: instantiate the existing `full_adder_4_bit` once (ports c_out, sum, a, b, c_in). No new sub-module.
- Slice mux and FSM stay in the controller.

Test Plan:
All cases use WORD_W=16.
1. Basic add: a=16'h1234, b=16'h0FED, c_in=0, out_ready=1 → out_valid 4 cycles after accept; sum=16'h2221, c_out=0, ovf=0.
2. Full carry ripple: a=16'hFFFF, b=16'h0001, c_in=0 → sum=16'h0000, c_out=1, ovf=0. Then a=16'h7FFF, b=16'h0001 → sum=16'h8000, c_out=0, ovf=1.
3. Carry-in across slices: a=16'h0009, b=16'h0006, c_in=1 → sum=16'h0010, c_out=0. Also a=16'hFFFF, b=16'h0000, c_in=1 → sum=16'h0000, c_out=1.
4. Backpressure: hold out_ready=0 for 6 cycles after out_valid → sum/c_out/ovf stable and in_ready=0 throughout. Raise out_ready with in_valid=0 → IDLE next cycle.
5. Back-to-back: in DONE with out_ready=1 and in_valid=1 (a=16'h0001, b=16'h0002) → first result retires and second is accepted at the same edge. Second result 16'h0003 appears 4 cycles later; no IDLE cycle.
6. Reset mid-operation: drop rst_n for one edge during RUN idx=2 → next cycle state IDLE, out_valid=0, sum=0, in_ready=1. A new request then completes correctly (a=16'h00FF, b=16'h0001 → 16'h0100).
